// File: rtl/tcm_bank_arbiter_if.sv
// Requester-side port of the TCM bank arbiter: one request/response channel
// carrying a single 32-bit access and its one-cycle-later response.
interface tcm_bank_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  strb;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, wdata, strb,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, strb,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/tcm_bank_arbiter.sv
// Shares the banked data TCM between the core and external ports: per-bank
// decode, same-cycle grants, round-robin conflict resolution, response routing.
module tcm_bank_arbiter #(
  parameter int unsigned BANK_NUM   = 32,
  parameter int unsigned BANK_WORDS = 512,
  parameter logic [31:0] BASE_ADDR  = 32'h8001_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  tcm_bank_arbiter_if.slave            core_if,
  tcm_bank_arbiter_if.slave            ext_if,
  output logic [BANK_NUM-1:0]          bank_en_o,
  output logic [BANK_NUM-1:0]          bank_we_o,
  output logic [BANK_NUM*$clog2(BANK_WORDS)-1:0] bank_addr_o,
  output logic [BANK_NUM*32-1:0]       bank_wdata_o,
  output logic [BANK_NUM*4-1:0]        bank_be_o,
  input  logic [BANK_NUM*32-1:0]       bank_rdata_i,
  output logic [15:0]                  conflict_cnt_o
);

  localparam int unsigned OFF_W  = $clog2(BANK_WORDS);
  localparam int unsigned BANK_W = $clog2(BANK_NUM);
  localparam int unsigned HI_LSB = OFF_W + BANK_W + 2;

  logic [BANK_W-1:0] w_core_bank, w_ext_bank;
  logic [OFF_W-1:0]  w_core_off, w_ext_off;
  logic              w_core_inr, w_ext_inr;
  logic              w_core_hit, w_ext_hit;
  logic              w_conflict, w_rr_ext;
  logic              w_core_win, w_ext_win;
  logic              w_core_gnt, w_ext_gnt;
  logic              w_unused_c;
  logic [31:0]       w_bank_rdata [BANK_NUM];

  logic [BANK_NUM-1:0] r_rr;
  logic [15:0]         r_cnt;
  logic                r_core_vld, r_core_we, r_core_err;
  logic                r_ext_vld, r_ext_we, r_ext_err;
  logic [BANK_W-1:0]   r_core_bank, r_ext_bank;

  // Address decode; byte offset within a word is irrelevant to the RAM.
  assign w_core_off  = core_if.addr[OFF_W+1:2];
  assign w_ext_off   = ext_if.addr[OFF_W+1:2];
  assign w_core_bank = core_if.addr[HI_LSB-1:OFF_W+2];
  assign w_ext_bank  = ext_if.addr[HI_LSB-1:OFF_W+2];
  assign w_core_inr  = (core_if.addr[31:HI_LSB] == BASE_ADDR[31:HI_LSB]);
  assign w_ext_inr   = (ext_if.addr[31:HI_LSB] == BASE_ADDR[31:HI_LSB]);
  assign w_unused_c  = ^{core_if.addr[1:0], ext_if.addr[1:0]};

  assign w_core_hit = rst_n & core_if.req & w_core_inr;
  assign w_ext_hit  = rst_n & ext_if.req & w_ext_inr;
  assign w_conflict = w_core_hit & w_ext_hit & (w_core_bank == w_ext_bank);
  assign w_rr_ext   = r_rr[w_core_bank];

  // Pointer only matters when both hit the same bank; otherwise each hit wins.
  assign w_core_win = w_core_hit & (~w_conflict | ~w_rr_ext);
  assign w_ext_win  = w_ext_hit & (~w_conflict | w_rr_ext);

  // Out-of-range requests are accepted at once and answered with an error.
  assign w_core_gnt = rst_n & core_if.req & (~w_core_inr | w_core_win);
  assign w_ext_gnt  = rst_n & ext_if.req & (~w_ext_inr | w_ext_win);
  assign core_if.gnt = w_core_gnt;
  assign ext_if.gnt  = w_ext_gnt;

  // Bank request fan-out; winners never share a bank so the else-if is exclusive.
  always_comb begin
    bank_en_o    = '0;
    bank_we_o    = '0;
    bank_addr_o  = '0;
    bank_wdata_o = '0;
    bank_be_o    = '0;
    for (int unsigned b = 0; b < BANK_NUM; b++) begin
      if (w_core_win && (w_core_bank == BANK_W'(b))) begin
        bank_en_o[b]                   = 1'b1;
        bank_we_o[b]                   = core_if.we;
        bank_addr_o[b*OFF_W +: OFF_W]  = w_core_off;
        bank_wdata_o[b*32 +: 32]       = core_if.wdata;
        bank_be_o[b*4 +: 4]            = core_if.we ? core_if.strb : 4'hF;
      end else if (w_ext_win && (w_ext_bank == BANK_W'(b))) begin
        bank_en_o[b]                   = 1'b1;
        bank_we_o[b]                   = ext_if.we;
        bank_addr_o[b*OFF_W +: OFF_W]  = w_ext_off;
        bank_wdata_o[b*32 +: 32]       = ext_if.wdata;
        bank_be_o[b*4 +: 4]            = ext_if.we ? ext_if.strb : 4'hF;
      end
    end
  end

  always_comb begin
    for (int unsigned b = 0; b < BANK_NUM; b++) begin
      w_bank_rdata[b] = bank_rdata_i[b*32 +: 32];
    end
  end

  // Response tracking, round-robin pointers and conflict counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr        <= '0;
      r_cnt       <= '0;
      r_core_vld  <= 1'b0;
      r_core_we   <= 1'b0;
      r_core_err  <= 1'b0;
      r_core_bank <= '0;
      r_ext_vld   <= 1'b0;
      r_ext_we    <= 1'b0;
      r_ext_err   <= 1'b0;
      r_ext_bank  <= '0;
    end else begin
      r_core_vld  <= w_core_gnt;
      r_core_we   <= core_if.we;
      r_core_err  <= ~w_core_inr;
      r_core_bank <= w_core_bank;
      r_ext_vld   <= w_ext_gnt;
      r_ext_we    <= ext_if.we;
      r_ext_err   <= ~w_ext_inr;
      r_ext_bank  <= w_ext_bank;
      if (w_conflict) begin
        r_rr[w_core_bank] <= ~w_rr_ext;
        if (r_cnt != 16'hFFFF) begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
    end
  end

  assign core_if.rvalid = r_core_vld;
  assign core_if.err    = r_core_vld & r_core_err;
  assign core_if.rdata  = (r_core_vld && !r_core_we && !r_core_err) ?
                          w_bank_rdata[r_core_bank] : 32'h0;
  assign ext_if.rvalid  = r_ext_vld;
  assign ext_if.err     = r_ext_vld & r_ext_err;
  assign ext_if.rdata   = (r_ext_vld && !r_ext_we && !r_ext_err) ?
                          w_bank_rdata[r_ext_bank] : 32'h0;
  assign conflict_cnt_o = r_cnt;

endmodule

// File: tb/tb_tcm_bank_arbiter.sv
// Directed bench for tcm_bank_arbiter: a pattern-filled RAM model behind the
// banks and per-port response queues filled at grant time.
module tb_tcm_bank_arbiter;
  localparam int unsigned BANK_NUM   = 32;
  localparam int unsigned BANK_WORDS = 512;
  localparam int unsigned OFF_W      = $clog2(BANK_WORDS);

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } resp_t;

  logic clk;
  logic rst_n;
  logic [BANK_NUM-1:0]       bank_en;
  logic [BANK_NUM-1:0]       bank_we;
  logic [BANK_NUM*OFF_W-1:0] bank_addr;
  logic [BANK_NUM*32-1:0]    bank_wdata;
  logic [BANK_NUM*4-1:0]     bank_be;
  logic [BANK_NUM*32-1:0]    bank_rdata;
  logic [15:0]               conflict_cnt;
  logic [31:0]               ram_q [BANK_NUM];

  int    pass_cnt = 0;
  int    fail_cnt = 0;
  int    chk_cnt  = 0;
  resp_t core_q[$];
  resp_t ext_q[$];

  tcm_bank_arbiter_if core_if ();
  tcm_bank_arbiter_if ext_if ();

  tcm_bank_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .core_if        (core_if),
    .ext_if         (ext_if),
    .bank_en_o      (bank_en),
    .bank_we_o      (bank_we),
    .bank_addr_o    (bank_addr),
    .bank_wdata_o   (bank_wdata),
    .bank_be_o      (bank_be),
    .bank_rdata_i   (bank_rdata),
    .conflict_cnt_o (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int b, input int w);
    return 32'hA500_0000 | 32'(b << 16) | 32'(w);
  endfunction

  // Each bank returns a known pattern of (bank, word) one cycle after enable.
  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(BANK_NUM); b++) begin
      if (bank_en[b] && !bank_we[b]) begin
        ram_q[b] <= pat(b, int'(bank_addr[b*OFF_W +: OFF_W]));
      end
    end
  end

  always_comb begin
    for (int b = 0; b < int'(BANK_NUM); b++) begin
      bank_rdata[b*32 +: 32] = ram_q[b];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic core_drv(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb);
    core_if.req = req; core_if.we = we; core_if.addr = addr;
    core_if.wdata = wdata; core_if.strb = strb;
  endtask

  task automatic ext_drv(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
    ext_if.req = req; ext_if.we = we; ext_if.addr = addr;
    ext_if.wdata = wdata; ext_if.strb = strb;
  endtask

  function automatic logic [31:0] baddr(input int b);
    return 32'(bank_addr[b*OFF_W +: OFF_W]);
  endfunction

  function automatic logic [31:0] bbe(input int b);
    return 32'(bank_be[b*4 +: 4]);
  endfunction

  // Response checker: a response must arrive exactly in the cycle after grant.
  always @(negedge clk) begin
    resp_t e;
    chk("core_rvalid", 32'(core_if.rvalid), 32'(core_q.size() != 0));
    if (core_if.rvalid && core_q.size() != 0) begin
      e = core_q.pop_front();
      chk("core_rdata", core_if.rdata, e.data);
      chk("core_err", 32'(core_if.err), 32'(e.err));
    end
    chk("ext_rvalid", 32'(ext_if.rvalid), 32'(ext_q.size() != 0));
    if (ext_if.rvalid && ext_q.size() != 0) begin
      e = ext_q.pop_front();
      chk("ext_rdata", ext_if.rdata, e.data);
      chk("ext_err", 32'(ext_if.err), 32'(e.err));
    end
  end

  initial begin
    logic exp_core [4];
    exp_core = '{1'b1, 1'b0, 1'b1, 1'b0};
    rst_n = 1'b0;
    core_drv(1'b1, 1'b0, 32'h8001_1814, 32'h0, 4'h0);
    ext_drv(1'b1, 1'b0, 32'h8001_0000, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_core_gnt", 32'(core_if.gnt), 32'h0);
    chk("rst_ext_gnt", 32'(ext_if.gnt), 32'h0);
    chk("rst_bank_en", bank_en, 32'h0);
    chk("rst_cnt", 32'(conflict_cnt), 32'h0);
    chk("rst_core_rdata", core_if.rdata, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    core_drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    ext_drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Lone core read of bank 3 word 5
    @(negedge clk);
    core_drv(1'b1, 1'b0, 32'h8001_1814, 32'h0, 4'h0);
    #1;
    chk("t1_core_gnt", 32'(core_if.gnt), 32'h1);
    chk("t1_bank_en", bank_en, 32'h0000_0008);
    chk("t1_bank_we", bank_we, 32'h0);
    chk("t1_bank_addr", baddr(3), 32'd5);
    chk("t1_bank_be", bbe(3), 32'hF);
    core_q.push_back('{err: 1'b0, data: pat(3, 5)});

    // Core read bank 0 alongside ext write bank 7
    @(negedge clk);
    core_drv(1'b1, 1'b0, 32'h8001_0004, 32'h0, 4'h0);
    ext_drv(1'b1, 1'b1, 32'h8001_3808, 32'h1234_5678, 4'hF);
    #1;
    chk("t2_core_gnt", 32'(core_if.gnt), 32'h1);
    chk("t2_ext_gnt", 32'(ext_if.gnt), 32'h1);
    chk("t2_bank_en", bank_en, 32'h0000_0081);
    chk("t2_bank_we", bank_we, 32'h0000_0080);
    chk("t2_bank7_addr", baddr(7), 32'd2);
    core_q.push_back('{err: 1'b0, data: pat(0, 1)});
    ext_q.push_back('{err: 1'b0, data: 32'h0});

    // Persistent conflict on bank 2 alternates winners
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      core_drv(1'b1, 1'b0, 32'h8001_1000, 32'h0, 4'h0);
      ext_drv(1'b1, 1'b0, 32'h8001_1010, 32'h0, 4'h0);
      #1;
      chk("t3_core_gnt", 32'(core_if.gnt), 32'(exp_core[i]));
      chk("t3_ext_gnt", 32'(ext_if.gnt), 32'(!exp_core[i]));
      chk("t3_bank2_addr", baddr(2), exp_core[i] ? 32'd0 : 32'd4);
      if (exp_core[i]) core_q.push_back('{err: 1'b0, data: pat(2, 0)});
      else             ext_q.push_back('{err: 1'b0, data: pat(2, 4)});
    end
    @(negedge clk);
    core_drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    chk("t3_cnt4", 32'(conflict_cnt), 32'd4);
    chk("t3_ext_alone_gnt", 32'(ext_if.gnt), 32'h1);
    ext_q.push_back('{err: 1'b0, data: pat(2, 4)});

    // Ext partial write to bank 31
    @(negedge clk);
    ext_drv(1'b1, 1'b1, 32'h8001_F80C, 32'hAABB_CCDD, 4'b0110);
    #1;
    chk("t4_cnt_hold", 32'(conflict_cnt), 32'd4);
    chk("t4_ext_gnt", 32'(ext_if.gnt), 32'h1);
    chk("t4_bank_we", bank_we, 32'h8000_0000);
    chk("t4_bank_be", bbe(31), 32'h6);
    chk("t4_bank_wdata", bank_wdata[31*32 +: 32], 32'hAABB_CCDD);
    chk("t4_bank_addr", baddr(31), 32'd3);
    ext_q.push_back('{err: 1'b0, data: 32'h0});

    // Out-of-range core beside in-range ext on the same bank field
    @(negedge clk);
    core_drv(1'b1, 1'b0, 32'h9000_0000, 32'h0, 4'h0);
    ext_drv(1'b1, 1'b0, 32'h8001_0000, 32'h0, 4'h0);
    #1;
    chk("t5_core_gnt", 32'(core_if.gnt), 32'h1);
    chk("t5_ext_gnt", 32'(ext_if.gnt), 32'h1);
    chk("t5_bank_en", bank_en, 32'h0000_0001);
    core_q.push_back('{err: 1'b1, data: 32'h0});
    ext_q.push_back('{err: 1'b0, data: pat(0, 0)});

    // Single conflict on bank 4 leaves its pointer at ext
    @(negedge clk);
    core_drv(1'b1, 1'b0, 32'h8001_2000, 32'h0, 4'h0);
    ext_drv(1'b1, 1'b0, 32'h8001_2004, 32'h0, 4'h0);
    #1;
    chk("t5_cnt_hold", 32'(conflict_cnt), 32'd4);
    chk("t6_core_gnt", 32'(core_if.gnt), 32'h1);
    chk("t6_ext_gnt", 32'(ext_if.gnt), 32'h0);
    core_q.push_back('{err: 1'b0, data: pat(4, 0)});
    @(negedge clk);
    core_drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    chk("t6_cnt5", 32'(conflict_cnt), 32'd5);
    chk("t6_ext_gnt2", 32'(ext_if.gnt), 32'h1);
    ext_q.push_back('{err: 1'b0, data: pat(4, 1)});

    // Reset right after a grant drops the response and clears state
    @(negedge clk);
    ext_drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    core_drv(1'b1, 1'b0, 32'h8001_0804, 32'h0, 4'h0);
    #1;
    chk("t7_core_gnt", 32'(core_if.gnt), 32'h1);
    core_q.push_back('{err: 1'b0, data: pat(1, 1)});
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    core_drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    core_q.delete();
    ext_q.delete();
    #1;
    chk("t7_rvalid", 32'(core_if.rvalid), 32'h0);
    chk("t7_cnt", 32'(conflict_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Bank 4 pointer must be back at core after reset
    @(negedge clk);
    core_drv(1'b1, 1'b0, 32'h8001_2000, 32'h0, 4'h0);
    ext_drv(1'b1, 1'b0, 32'h8001_2004, 32'h0, 4'h0);
    #1;
    chk("t8_core_gnt", 32'(core_if.gnt), 32'h1);
    chk("t8_ext_gnt", 32'(ext_if.gnt), 32'h0);
    core_q.push_back('{err: 1'b0, data: pat(4, 0)});
    @(negedge clk);
    core_drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    chk("t8_ext_gnt2", 32'(ext_if.gnt), 32'h1);
    ext_q.push_back('{err: 1'b0, data: pat(4, 1)});
    @(negedge clk);
    ext_drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("t8_cnt", 32'(conflict_cnt), 32'd1);
    chk("drain_core_q", 32'(core_q.size()), 32'h0);
    chk("drain_ext_q", 32'(ext_q.size()), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
